// File: rtl/hv_sram_sequencer_if.sv
// Handshake bundle between the SRAM read sequencer and its environment
// (nine SRAM banks in three groups plus the encoder datapath).
interface hv_sram_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  StartValid_SI;
  logic                  StartReady_SO;
  logic [8:0]            SramReady_SI;
  logic [8:0]            SramValid_SI;
  logic [2:0]            ReqValid_SO;
  logic [2:0]            RespReady_SO;
  logic [ADDR_WIDTH-1:0] SramAddr_DO;
  logic                  ChunkValid_SO;
  logic                  ChunkReady_SI;
  logic                  ChunkLast_SO;
  logic                  Done_SO;
  logic                  Error_SO;

  // Sequencer side
  modport master (
    input  StartValid_SI, SramReady_SI, SramValid_SI, ChunkReady_SI,
    output StartReady_SO, ReqValid_SO, RespReady_SO, SramAddr_DO,
           ChunkValid_SO, ChunkLast_SO, Done_SO, Error_SO
  );

  // Environment side (SRAM banks, datapath, sample source)
  modport slave (
    output StartValid_SI, SramReady_SI, SramValid_SI, ChunkReady_SI,
    input  StartReady_SO, ReqValid_SO, RespReady_SO, SramAddr_DO,
           ChunkValid_SO, ChunkLast_SO, Done_SO, Error_SO
  );
endinterface

// File: rtl/hv_sram_sequencer.sv
// SRAM read sequencer for the spatial encoder. For each accepted sample it
// walks rows 0..NUM_CHUNKS-1, requests every row from all nine banks
// (IM, projM-neg, projM-pos; three banks each), waits for all nine responses
// and hands one chunk-ready strobe to the datapath. A watchdog aborts the
// sample if a bank hangs.
module hv_sram_sequencer #(
  parameter int NUM_CHUNKS     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                Clk_CI,
  input  logic                Reset_RI,
  hv_sram_sequencer_if.master bus
);

  localparam int                    TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_CHUNKS - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [8:0]             acc_q, acc_d;     // sticky per-bank request accepts
  logic [8:0]             rsp_q, rsp_d;     // sticky per-bank responses
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   error_q, error_d;
  logic                   done_q, done_d;

  logic       in_issue;
  logic       capturing;
  logic       acc_all;
  logic       rsp_all;
  logic       last_chunk;
  logic       timer_expired;
  logic       abort;
  logic [2:0] req_valid;
  logic [2:0] resp_ready;

  assign in_issue      = (state_q == S_ISSUE);
  assign capturing     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  // A bank's own live strobe completes the set in the same cycle it arrives.
  assign acc_all       = &(acc_q | bus.SramReady_SI);
  assign rsp_all       = &(rsp_q | bus.SramValid_SI);
  assign last_chunk    = (addr_q == LAST_ADDR);
  // timer_q counts completed ISSUE/WAIT cycles, so +1 is the current one.
  assign timer_expired = (TIMER_WIDTH'(timer_q + 1'b1) == TIMEOUT_VAL);

  // Next-state logic: chunk sequencing, flag capture and watchdog abort.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    rsp_d   = rsp_q;
    timer_d = timer_q;
    error_d = error_q;
    done_d  = 1'b0;
    abort   = 1'b0;

    if (in_issue) begin
      acc_d = acc_q | bus.SramReady_SI;
    end
    if (capturing) begin
      rsp_d   = rsp_q | bus.SramValid_SI;
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.StartValid_SI) begin
          state_d = S_ISSUE;
          addr_d  = '0;
          acc_d   = '0;
          rsp_d   = '0;
          timer_d = '0;
          error_d = 1'b0;
        end
      end
      S_ISSUE: begin
        // A chunk that completes on the final allowed cycle wins over the watchdog.
        if (acc_all && rsp_all) begin
          state_d = S_EMIT;
        end else if (timer_expired) begin
          abort = 1'b1;
        end else if (acc_all) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_all) begin
          state_d = S_EMIT;
        end else if (timer_expired) begin
          abort = 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.ChunkReady_SI) begin
          acc_d   = '0;
          rsp_d   = '0;
          timer_d = '0;
          if (last_chunk) begin
            state_d = S_IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Hung bank: drop everything, flag it, no Done.
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      acc_d   = '0;
      rsp_d   = '0;
      timer_d = '0;
      error_d = 1'b1;
    end
  end

  // State and flag registers; reset aborts any chunk in flight immediately.
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      rsp_q   <= '0;
      timer_q <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      timer_q <= timer_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  // Per-group handshakes, decoded from registered flags only.
  always_comb begin
    req_valid  = '0;
    resp_ready = '0;
    for (int g = 0; g < 3; g++) begin
      req_valid[g]  = in_issue  && !(&acc_q[3*g +: 3]);
      resp_ready[g] = capturing && !(&rsp_q[3*g +: 3]);
    end
  end

  assign bus.ReqValid_SO   = req_valid;
  assign bus.RespReady_SO  = resp_ready;
  assign bus.StartReady_SO = (state_q == S_IDLE);
  assign bus.SramAddr_DO   = addr_q;
  assign bus.ChunkValid_SO = (state_q == S_EMIT);
  assign bus.ChunkLast_SO  = (state_q == S_EMIT) && last_chunk;
  assign bus.Done_SO       = done_q;
  assign bus.Error_SO      = error_q;

endmodule

// File: tb/tb_hv_sram_sequencer.sv
// Self-checking bench for hv_sram_sequencer. Each chunk gets a per-bank
// accept delay and response delay (cycles after the chunk's ISSUE entry) and a
// datapath stall; expected outputs per cycle follow from those delays with
// plain max/compare arithmetic.
module tb_hv_sram_sequencer;

  localparam int NUM_CHUNKS     = 4;
  localparam int ADDR_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic Clk_CI   = 1'b0;
  logic Reset_RI = 1'b0;

  hv_sram_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  hv_sram_sequencer #(
    .NUM_CHUNKS    (NUM_CHUNKS),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk_CI  (Clk_CI),
    .Reset_RI(Reset_RI),
    .bus     (bus)
  );

  always #5 Clk_CI = ~Clk_CI;

  int   n_vec    = 0;
  int   n_err    = 0;
  logic exp_done = 1'b0;
  logic exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; the bench always sits just after a falling edge.
  task automatic step();
    @(posedge Clk_CI);
    @(negedge Clk_CI);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".start_ready"}, 32'(bus.StartReady_SO), 1);
    check({tag, ".chunk_valid"}, 32'(bus.ChunkValid_SO), 0);
    check({tag, ".chunk_last"},  32'(bus.ChunkLast_SO),  0);
    check({tag, ".req_valid"},   32'(bus.ReqValid_SO),   0);
    check({tag, ".resp_ready"},  32'(bus.RespReady_SO),  0);
    check({tag, ".addr"},        32'(bus.SramAddr_DO),   0);
    check({tag, ".done"},        32'(bus.Done_SO),       0);
    check({tag, ".error"},       32'(bus.Error_SO),      0);
  endtask

  // One idle cycle; sv decides whether a sample is offered at its end.
  task automatic idle_cycle(input logic sv);
    check("idle.start_ready", 32'(bus.StartReady_SO), 1);
    check("idle.chunk_valid", 32'(bus.ChunkValid_SO), 0);
    check("idle.chunk_last",  32'(bus.ChunkLast_SO),  0);
    check("idle.req_valid",   32'(bus.ReqValid_SO),   0);
    check("idle.resp_ready",  32'(bus.RespReady_SO),  0);
    check("idle.addr",        32'(bus.SramAddr_DO),   0);
    check("idle.done",        32'(bus.Done_SO),       32'(exp_done));
    check("idle.error",       32'(bus.Error_SO),      32'(exp_err));
    bus.StartValid_SI = sv;
    bus.SramReady_SI  = 9'($urandom);
    bus.SramValid_SI  = 9'($urandom);
    bus.ChunkReady_SI = 1'($urandom);
    step();
    exp_done = 1'b0;
    if (sv) exp_err = 1'b0;
  endtask

  // mode 0: random, 1: zero delays, 2: bank7 accept +3 / bank2 response +5 at
  // row 0 and 10-cycle stall at row 1, 3: bank 4 never responds at row 1,
  // 4: reset pulse while waiting at row 2.
  task automatic run_sample(input int mode);
    int         dr[9];
    int         dv[9];
    int         cr, a, v, e, gr, gv;
    logic [2:0] rq, rs;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      for (int k = 0; k < 9; k++) begin
        dr[k] = $urandom_range(0, 4);
        dv[k] = $urandom_range(0, 6);
      end
      cr = $urandom_range(0, 3);
      if (mode == 1 || (mode == 2 && c == 0) || (mode == 4 && c == 2)) begin
        for (int k = 0; k < 9; k++) begin
          dr[k] = 0;
          dv[k] = 0;
        end
        cr = 0;
      end
      if (mode == 2 && c == 0) begin
        dr[7] = 3;
        dv[2] = 5;
      end
      if (mode == 2 && c == 1) cr = 10;
      if (mode == 3 && c == 1) dv[4] = 1000;
      if (mode == 4 && c == 2) dv[0] = 6;

      a = 0;
      v = 0;
      for (int k = 0; k < 9; k++) begin
        if (dr[k] > a) a = dr[k];
        if (dv[k] > v) v = dv[k];
      end
      e = (a > v) ? a : v;

      // Request/response phase: lasts e+1 cycles unless the watchdog fires.
      for (int i = 0; i <= e && i < TIMEOUT_CYCLES; i++) begin
        for (int g = 0; g < 3; g++) begin
          gr = 0;
          gv = 0;
          for (int k = 3 * g; k < 3 * g + 3; k++) begin
            if (dr[k] > gr) gr = dr[k];
            if (dv[k] > gv) gv = dv[k];
          end
          rq[g] = (i <= gr);
          rs[g] = (i <= gv);
        end
        check("issue.req_valid",   32'(bus.ReqValid_SO),   32'(rq));
        check("issue.resp_ready",  32'(bus.RespReady_SO),  32'(rs));
        check("issue.chunk_valid", 32'(bus.ChunkValid_SO), 0);
        check("issue.start_ready", 32'(bus.StartReady_SO), 0);
        check("issue.addr",        32'(bus.SramAddr_DO),   32'(c));
        check("issue.done",        32'(bus.Done_SO),       0);
        check("issue.error",       32'(bus.Error_SO),      0);

        if (mode == 4 && c == 2 && i == 2) begin
          bus.StartValid_SI = 1'b0;
          bus.SramReady_SI  = '0;
          bus.SramValid_SI  = '0;
          bus.ChunkReady_SI = 1'b0;
          #1 Reset_RI = 1'b0;
          #1 check_reset_values("midreset");
          #1 Reset_RI = 1'b1;
          @(negedge Clk_CI);
          exp_done = 1'b0;
          exp_err  = 1'b0;
          return;
        end

        for (int k = 0; k < 9; k++) begin
          bus.SramReady_SI[k] = (i < dr[k]) ? 1'b0 : (i == dr[k]) ? 1'b1 : 1'($urandom);
          bus.SramValid_SI[k] = (i < dv[k]) ? 1'b0 : (i == dv[k]) ? 1'b1 : 1'($urandom);
        end
        bus.StartValid_SI = 1'($urandom);
        bus.ChunkReady_SI = 1'($urandom);
        step();
      end

      if (e >= TIMEOUT_CYCLES) begin
        exp_err  = 1'b1;
        exp_done = 1'b0;
        return;
      end

      // Chunk presented; datapath stalls cr cycles before consuming it.
      for (int j = 0; j <= cr; j++) begin
        check("emit.chunk_valid", 32'(bus.ChunkValid_SO), 1);
        check("emit.chunk_last",  32'(bus.ChunkLast_SO),  32'(c == NUM_CHUNKS - 1));
        check("emit.addr",        32'(bus.SramAddr_DO),   32'(c));
        check("emit.req_valid",   32'(bus.ReqValid_SO),   0);
        check("emit.resp_ready",  32'(bus.RespReady_SO),  0);
        check("emit.start_ready", 32'(bus.StartReady_SO), 0);
        check("emit.done",        32'(bus.Done_SO),       0);
        bus.ChunkReady_SI = (j == cr);
        bus.SramReady_SI  = 9'($urandom);
        bus.SramValid_SI  = 9'($urandom);
        bus.StartValid_SI = 1'($urandom);
        step();
      end
    end
    exp_done = 1'b1;
  endtask

  initial begin
    bus.StartValid_SI = 1'b0;
    bus.SramReady_SI  = '0;
    bus.SramValid_SI  = '0;
    bus.ChunkReady_SI = 1'b0;
    #1 check_reset_values("reset");
    @(negedge Clk_CI);
    Reset_RI = 1'b1;

    idle_cycle(1'b1); run_sample(1);
    idle_cycle(1'b0); idle_cycle(1'b1); run_sample(2);
    idle_cycle(1'b1); run_sample(3);
    idle_cycle(1'b0); idle_cycle(1'b1); run_sample(0);
    idle_cycle(1'b1); run_sample(4);
    idle_cycle(1'b1); run_sample(0);

    for (int s = 0; s < 40; s++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(1'b0);
      idle_cycle(1'b1);
      run_sample(($urandom_range(0, 7) == 0) ? 3 : 0);
    end
    idle_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
